// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchronizer feeding a stability-counter FSM; emits a clean level plus edge pulses.
// Define DEBOUNCE_INVERT_EN to present the inverted level (sw_out resets to 1, pulses follow the inverted sw_out).
module switch_debouncer #(
   parameter int STABLE_CYCLES = 1000000,
   parameter int CNT_WIDTH     = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_in,
   output logic sw_out,
   output logic rise_pulse,
   output logic fall_pulse
);
`ifdef DEBOUNCE_INVERT_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
   typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
   state_t state_q;
   logic s1_q, s2_q, out_q, rise_q, fall_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= sw_in;
         s2_q <= s1_q;
      end
   end
   // Inversion only remaps the registered outputs; counting and state are identical in both builds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         out_q   <= INV;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state_q)
            IDLE_LOW:
               if (s2_q) begin
                  state_q <= WAIT_HIGH;
                  cnt_q   <= '0;
               end
            WAIT_HIGH:
               if (!s2_q) begin
                  state_q <= IDLE_LOW;
                  cnt_q   <= '0;
               end else if (cnt_q == LAST) begin
                  state_q <= IDLE_HIGH;
                  cnt_q   <= '0;
                  out_q   <= ~INV;
                  rise_q  <= ~INV;
                  fall_q  <= INV;
               end else
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
            IDLE_HIGH:
               if (!s2_q) begin
                  state_q <= WAIT_LOW;
                  cnt_q   <= '0;
               end
            WAIT_LOW:
               if (s2_q) begin
                  state_q <= IDLE_HIGH;
                  cnt_q   <= '0;
               end else if (cnt_q == LAST) begin
                  state_q <= IDLE_LOW;
                  cnt_q   <= '0;
                  out_q   <= INV;
                  rise_q  <= INV;
                  fall_q  <= ~INV;
               end else
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
            default: begin
               state_q <= IDLE_LOW;
               cnt_q   <= '0;
            end
         endcase
      end
   end
   assign sw_out     = out_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: vector table plus hand sequences for reset corners, STABLE_CYCLES=8.
module tb_switch_debouncer;
`ifdef DEBOUNCE_INVERT_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, sw_in = 1'b0;
   logic sw_out, rise_pulse, fall_pulse;
   int tests = 0, fails = 0;
   typedef struct {logic sw; logic out; logic rise; logic fall;} vec_t;
   vec_t vecs[$];
   switch_debouncer #(.STABLE_CYCLES(8), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
      .sw_out(sw_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
   );
   always #5 clk = ~clk;
   // Expectations are written for the physical (non-inverted) level and remapped here.
   task automatic check(input string name, input logic o, input logic r, input logic f);
      logic [2:0] want, got;
      want = {o ^ INV, INV ? f : r, INV ? r : f};
      got  = {sw_out, rise_pulse, fall_pulse};
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: out/rise/fall got %b want %b at %0t", name, got, want, $time);
      end
   endtask
   task automatic step(input string name, input logic sw, input logic o, input logic r, input logic f);
      @(negedge clk);
      sw_in = sw;
      @(posedge clk);
      #1;
      check(name, o, r, f);
   endtask
   task automatic add(input logic sw, input logic o, input logic r, input logic f, input int n);
      for (int i = 0; i < n; i++) vecs.push_back('{sw, o, r, f});
   endtask
   initial begin
      add(1, 0, 0, 0, 10); add(1, 1, 1, 0, 1); add(1, 1, 0, 0, 1);
      add(0, 1, 0, 0, 10); add(0, 0, 0, 1, 1); add(0, 0, 0, 0, 1);
      add(1, 0, 0, 0, 5);  add(0, 0, 0, 0, 2);
      add(1, 0, 0, 0, 10); add(1, 1, 1, 0, 1); add(1, 1, 0, 0, 1);
      add(0, 1, 0, 0, 10); add(0, 0, 0, 1, 1); add(0, 0, 0, 0, 1);
      add(1, 0, 0, 0, 7);  add(0, 0, 0, 0, 14);
      for (int i = 0; i < 6; i++) step("reset_hold", i[0], 0, 0, 0);
      sw_in = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step("idle", 0, 0, 0, 0);
      for (int i = 0; i < vecs.size(); i++)
         step($sformatf("vec%0d", i), vecs[i].sw, vecs[i].out, vecs[i].rise, vecs[i].fall);
      for (int i = 0; i < 5; i++) step("pre_rst", 1, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst", 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_hold", 0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step("post_rst", 1, 0, 0, 0);
      step("post_rst_rise", 1, 1, 1, 0);
      step("post_rst_after", 1, 1, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst", 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions a raw, bouncing slide-switch or push-button input from the lab board into a clean, glitch-free logic level for downstream gate logic.
- Also produces single-cycle edge pulses for downstream sequential stages.
- Sits directly between the board I/O pin and the gate-level blocks (e.g. the inverter under test), so gates see a stable level instead of mechanical bounce.

Parameters:
- STABLE_CYCLES, 1000000, consecutive synchronized cycles the input must hold a new value before it is accepted (10 ms at 100 MHz); legal range 2 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 20, width of the stability counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- sw_in  input  1  raw switch input, asynchronous to clk, may bounce
- sw_out  output  1  debounced level, registered
- rise_pulse  output  1  one-cycle pulse when sw_out goes 0->1
- fall_pulse  output  1  one-cycle pulse when sw_out goes 1->0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - synchronizer flops s1, s2 = 0; counter = 0; state = IDLE_LOW.
  - sw_out = 0, rise_pulse = 0, fall_pulse = 0.
  - Reset mid-debounce abandons the count; no pulse is emitted.
- Synchronizer: two-flop chain sw_in -> s1 -> s2. Only s2 feeds the FSM.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - IDLE_LOW: s2=1 -> WAIT_HIGH, cnt=0; else stay.
  - WAIT_HIGH:
    - s2=0 -> IDLE_LOW, cnt=0 (bounce rejected).
    - s2=1 and cnt==STABLE_CYCLES-1 -> IDLE_HIGH, sw_out<=1, rise_pulse<=1, cnt=0.
    - Otherwise cnt<=cnt+1.
  - IDLE_HIGH / WAIT_LOW: mirror image (s2=0 starts WAIT_LOW; acceptance sets sw_out<=0, fall_pulse<=1).
- Latency: for a clean step on sw_in meeting setup before edge 1, sw_out and the pulse change at edge STABLE_CYCLES+3. The pulse is high for exactly one cycle.
- Bounce rejection:
  - Any s2 excursion back to the stable level during WAIT restarts the count from 0.
  - A pulse on s2 shorter than STABLE_CYCLES cycles never changes sw_out.
- rise_pulse and fall_pulse are never high in the same cycle. Each is cleared to 0 on every cycle it is not being set.
- Counter never wraps: it is reset on every WAIT exit, and max count STABLE_CYCLES-1 fits in CNT_WIDTH.
- If sw_in is held high through reset release, the block debounces to high normally: rise_pulse occurs at edge STABLE_CYCLES+3 after rst_n deasserts.

Optional Feature:
- Macro: DEBOUNCE_INVERT_EN.
- Defined:
  - sw_out presents the inverted debounced level; reset value of sw_out = 1.
  - rise_pulse fires when the inverted sw_out goes 0->1 (physical switch released); fall_pulse fires when it goes 1->0.
  - Internal FSM, latency and counting are unchanged; only output mapping changes.
- Not defined: non-inverted behaviour exactly as above.

Test Plan (STABLE_CYCLES=8, CNT_WIDTH=4, 10 ns clock):
- Reset: hold rst_n=0 with sw_in toggling -> sw_out=0, rise_pulse=0, fall_pulse=0 throughout. Assert rst_n=0 asynchronously mid-cycle -> outputs clear immediately without waiting for clk.
- Clean press: sw_in 0->1 before edge 1, then held -> sw_out=1 and rise_pulse=1 at edge 11. rise_pulse=0 at edge 12. fall_pulse stays 0.
- Bounce: sw_in 1 for 5 cycles, 0 for 2, then 1 steady -> no pulse during bounce. rise_pulse occurs 11 edges after the final 0->1 transition.
- Short glitch: sw_in high for 7 cycles, then low -> sw_out remains 0; rise_pulse and fall_pulse never assert.
- Release: from sw_out=1, sw_in 1->0 held -> sw_out=0 and fall_pulse=1 for one cycle at edge 11.
- Reset mid-debounce and invert mode:
  - Assert rst_n during WAIT_HIGH at cycle 5, release with sw_in=1 -> no pulse at the old deadline; rise_pulse 11 edges after release.
  - With DEBOUNCE_INVERT_EN defined, repeat the clean press -> sw_out=1 out of reset, 0 at edge 11, fall_pulse=1 at edge 11.
